// File: rtl/pif_ram_arbiter.sv
// Two-requester arbiter for the single-port PIF RAM: N64 has priority, a starvation
// counter bounds the CPU wait, and every grant runs IDLE -> ISSUE -> CAPTURE -> DONE.
module pif_ram_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n64_req,
  input  logic              n64_wren,
  input  logic [ADDR_W-1:0] n64_addr,
  input  logic [DATA_W-1:0] n64_wdata,
  output logic              n64_ack,
  output logic [DATA_W-1:0] n64_rdata,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              pif_disable,
  output logic              ram_en,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;
  logic       grant, grant_cpu;

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    grant          = 1'b0;
    grant_cpu      = 1'b0;
    case (state)
      IDLE: begin
        if (pif_disable) begin
          starve_cnt_nxt = 4'd0;
          if (cpu_req) begin
            grant     = 1'b1;
            grant_cpu = 1'b1;
          end
        end else if (cpu_req && starve_cnt == LIMIT) begin
          grant          = 1'b1;
          grant_cpu      = 1'b1;
          starve_cnt_nxt = 4'd0;
        end else if (n64_req) begin
          grant = 1'b1;
          // Only count N64 wins that actually kept a pending CPU waiting.
          if (!cpu_req)
            starve_cnt_nxt = 4'd0;
          else if (starve_cnt != LIMIT)
            starve_cnt_nxt = starve_cnt + 4'd1;
        end else begin
          starve_cnt_nxt = 4'd0;
          if (cpu_req) begin
            grant     = 1'b1;
            grant_cpu = 1'b1;
          end
        end
        if (grant) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      owner      <= 1'b0;
      ram_wren   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      n64_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      // Arbitration stage: latch the winner's request onto the RAM bus.
      if (grant) begin
        owner     <= grant_cpu;
        ram_wren  <= grant_cpu ? cpu_wren  : n64_wren;
        ram_addr  <= grant_cpu ? cpu_addr  : n64_addr;
        ram_wdata <= grant_cpu ? cpu_wdata : n64_wdata;
      end
      // Capture stage: only the owner's read register is updated.
      if (state == CAPTURE && !ram_wren) begin
        if (owner) cpu_rdata <= ram_rdata;
        else       n64_rdata <= ram_rdata;
      end
    end
  end

  assign ram_en  = (state == ISSUE);
  assign n64_ack = (state == DONE) && !owner;
  assign cpu_ack = (state == DONE) && owner;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Directed bench for pif_ram_arbiter with a behavioural one-cycle-latency RAM.
module tb_pif_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        n64_req, n64_wren, cpu_req, cpu_wren, pif_disable;
  logic [8:0]  n64_addr, cpu_addr, ram_addr;
  logic [31:0] n64_wdata, cpu_wdata, n64_rdata, cpu_rdata, ram_wdata, ram_rdata;
  logic        n64_ack, cpu_ack, ram_en, ram_wren, busy, owner;

  logic [31:0] mem [0:511];
  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  int          grants[$];
  int          n64_acks, cpu_acks;
  logic [31:0] rd;

  pif_ram_arbiter #(.ADDR_W(9), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .n64_req(n64_req), .n64_wren(n64_wren), .n64_addr(n64_addr), .n64_wdata(n64_wdata),
    .n64_ack(n64_ack), .n64_rdata(n64_rdata),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .pif_disable(pif_disable),
    .ram_en(ram_en), .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ram_en) grants.push_back(int'(owner));
    if (n64_ack) n64_acks++;
    if (cpu_ack) cpu_acks++;
  endtask

  task automatic access(input logic who, input logic wr, input logic [8:0] a,
                        input logic [31:0] d, output logic [31:0] rdat);
    if (who) begin
      cpu_req = 1'b1; cpu_wren = wr; cpu_addr = a; cpu_wdata = d;
    end else begin
      n64_req = 1'b1; n64_wren = wr; n64_addr = a; n64_wdata = d;
    end
    step();
    chk1("issue_en", ram_en, 1'b1);
    chk1("issue_owner", owner, who);
    chk1("issue_wren", ram_wren, wr);
    chk32("issue_addr", 32'(ram_addr), 32'(a));
    if (wr) chk32("issue_wdata", ram_wdata, d);
    step();
    chk1("capture_en", ram_en, 1'b0);
    chk1("capture_no_ack", n64_ack | cpu_ack, 1'b0);
    step();
    chk1("done_ack", who ? cpu_ack : n64_ack, 1'b1);
    chk1("done_other_ack", who ? n64_ack : cpu_ack, 1'b0);
    rdat = who ? cpu_rdata : n64_rdata;
    if (who) cpu_req = 1'b0; else n64_req = 1'b0;
    step();
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_no_ack", n64_ack | cpu_ack, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[0] = 32'h12345678;
    ram_rdata = 32'h0;
    reset = 1'b1; pif_disable = 1'b0;
    n64_req = 1'b0; n64_wren = 1'b0; n64_addr = '0; n64_wdata = '0;
    cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    n64_acks = 0; cpu_acks = 0;

    // Reset state
    step(); step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_acks", n64_ack | cpu_ack, 1'b0);
    chk32("rst_n64_rdata", n64_rdata, 32'h0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    step();

    // CPU write then read, no contention
    access(1'b1, 1'b1, 9'h1FF, 32'hDEADBEEF, rd);
    access(1'b1, 1'b0, 9'h1FF, 32'h0, rd);
    chk32("cpu_read_1ff", rd, 32'hDEADBEEF);
    chk32("n64_acks_none", 32'(n64_acks), 32'd0);

    // Both requesting continuously: N,N,N,N,C repeating
    grants.delete();
    n64_acks = 0; cpu_acks = 0;
    n64_req = 1'b1; n64_wren = 1'b0; n64_addr = 9'h002;
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 9'h003;
    for (int k = 0; k < 40; k++) step();
    n64_req = 1'b0; cpu_req = 1'b0;
    chk32("starve_grant_count", 32'(grants.size()), 32'd10);
    for (int g = 0; g < 10; g++)
      if (g < grants.size())
        chk32($sformatf("starve_grant_%0d", g), 32'(grants[g]), (g % 5 == 4) ? 32'd1 : 32'd0);
    chk32("starve_n64_acks", 32'(n64_acks), 32'd8);
    chk32("starve_cpu_acks", 32'(cpu_acks), 32'd2);
    step();
    chk1("starve_idle", busy, 1'b0);

    // pif_disable with both requesting
    grants.delete();
    n64_acks = 0; cpu_acks = 0;
    pif_disable = 1'b1;
    n64_req = 1'b1; cpu_req = 1'b1;
    for (int k = 0; k < 16; k++) step();
    chk32("dis_cpu_acks", 32'(cpu_acks), 32'd4);
    chk32("dis_n64_acks", 32'(n64_acks), 32'd0);
    chk1("dis_idle", busy, 1'b0);
    pif_disable = 1'b0;
    step();
    chk1("undis_en", ram_en, 1'b1);
    chk1("undis_owner", owner, 1'b0);
    step(); step();
    chk1("undis_n64_ack", n64_ack, 1'b1);
    n64_req = 1'b0; cpu_req = 1'b0;
    step();

    // pif_disable raised while an N64 access is in ISSUE
    n64_req = 1'b1; cpu_req = 1'b1;
    step();
    chk1("mid_issue_owner", owner, 1'b0);
    chk1("mid_issue_en", ram_en, 1'b1);
    pif_disable = 1'b1;
    step(); step();
    chk1("mid_n64_ack", n64_ack, 1'b1);
    step();
    step();
    chk1("mid_next_en", ram_en, 1'b1);
    chk1("mid_next_owner", owner, 1'b1);
    step(); step();
    chk1("mid_cpu_ack", cpu_ack, 1'b1);
    chk1("mid_no_n64_ack", n64_ack, 1'b0);
    n64_req = 1'b0; cpu_req = 1'b0; pif_disable = 1'b0;
    step();

    // Reset during CAPTURE of a CPU read
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 9'h1FF;
    step();
    step();
    chk1("rc_capture_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    chk1("rc_busy", busy, 1'b0);
    chk1("rc_no_ack", cpu_ack, 1'b0);
    chk32("rc_rdata_cleared", cpu_rdata, 32'h0);
    reset = 1'b0;
    step();
    chk1("rc_re_en", ram_en, 1'b1);
    step();
    chk1("rc_re_no_ack", cpu_ack, 1'b0);
    step();
    chk1("rc_re_ack", cpu_ack, 1'b1);
    chk32("rc_re_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    step();

    // Read data isolation
    access(1'b0, 1'b0, 9'h000, 32'h0, rd);
    chk32("iso_n64_rdata", rd, 32'h12345678);
    access(1'b1, 1'b0, 9'h001, 32'h0, rd);
    chk32("iso_cpu_rdata", rd, 32'h0);
    chk32("iso_n64_hold", n64_rdata, 32'h12345678);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
